// File: rtl/axis_adder_pkg.sv
// Shared helpers for the AXI-Stream multi-operand adder: the result width is
// derived here so the block and anything that instantiates it agree on it.
package axis_adder_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Widened so the sum of NUM_OPERANDS full-scale operands can never overflow
  function automatic int out_width(input int width, input int num_operands);
    return width + clog2(num_operands);
  endfunction

endpackage

// File: rtl/adder_tree_comb.sv
// Purely combinational extend-and-sum of NUM_OPERANDS packed operands,
// zero- or sign-extended to the full result width before adding.
module adder_tree_comb
  import axis_adder_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int NUM_OPERANDS = 2,
  parameter int SIGNED       = 0
) (
  input  logic [NUM_OPERANDS*WIDTH-1:0]              operands,
  output logic [out_width(WIDTH, NUM_OPERANDS)-1:0]  sum
);

  localparam int OUT_WIDTH = out_width(WIDTH, NUM_OPERANDS);

  logic [OUT_WIDTH-1:0] extended [NUM_OPERANDS];

  // Extension happens before the add, so the sum is exact in OUT_WIDTH bits
  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_extend
    logic [WIDTH-1:0] operand;
    logic             fill_bit;
    assign operand     = operands[k*WIDTH +: WIDTH];
    assign fill_bit    = (SIGNED != 0) & operand[WIDTH-1];
    assign extended[k] = {{(OUT_WIDTH-WIDTH){fill_bit}}, operand};
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      sum = sum + extended[k];
    end
  end

endmodule

// File: rtl/axis_adder_tree.sv
// Two-stage pipelined multi-operand adder with AXI-Stream slave/master ports.
// s_axis_tready is combinational from m_axis_tready so the pipe never bubbles.
module axis_adder_tree
  import axis_adder_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int NUM_OPERANDS = 2,
  parameter int SIGNED       = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_OPERANDS*WIDTH-1:0]             s_axis_tdata,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic [out_width(WIDTH, NUM_OPERANDS)-1:0] m_axis_tdata,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready
);

  localparam int OUT_WIDTH = out_width(WIDTH, NUM_OPERANDS);

  logic [NUM_OPERANDS*WIDTH-1:0] data1;
  logic                          last1;
  logic                          v1;
  logic [OUT_WIDTH-1:0]          data2;
  logic                          last2;
  logic                          v2;
  logic [OUT_WIDTH-1:0]          sum1;
  logic                          adv1;
  logic                          adv2;
  logic                          accept;

  adder_tree_comb #(
    .WIDTH        (WIDTH),
    .NUM_OPERANDS (NUM_OPERANDS),
    .SIGNED       (SIGNED)
  ) u_sum (
    .operands (data1),
    .sum      (sum1)
  );

  // A stage may advance when it is empty or the stage after it is moving
  assign adv2          = !v2 | m_axis_tready;
  assign adv1          = !v1 | adv2;
  assign s_axis_tready = adv1 & !reset;
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      data1 <= '0;
      last1 <= 1'b0;
      v1    <= 1'b0;
      data2 <= '0;
      last2 <= 1'b0;
      v2    <= 1'b0;
    end else begin
      if (accept) begin
        data1 <= s_axis_tdata;
        last1 <= s_axis_tlast;
        v1    <= 1'b1;
      end else if (adv2) begin
        v1    <= 1'b0;
      end
      if (adv2) begin
        data2 <= sum1;
        last2 <= last1;
        v2    <= v1;
      end
    end
  end

  assign m_axis_tdata  = data2;
  assign m_axis_tlast  = last2;
  assign m_axis_tvalid = v2;

endmodule

// File: tb/tb_axis_adder_tree.sv
// Directed and scoreboarded bench for axis_adder_tree; an unsigned and a signed
// instance (WIDTH=4, NUM_OPERANDS=3) share one stimulus stream.
module tb_axis_adder_tree;
  import axis_adder_pkg::*;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int OW = out_width(W, N);

  typedef struct {
    logic [N*W-1:0] tdata;
    logic           last;
    logic [OW-1:0]  sum_u;
    logic [OW-1:0]  sum_s;
  } vector_t;

  typedef struct {
    logic [OW-1:0] sum_u;
    logic [OW-1:0] sum_s;
    logic          last;
  } expect_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           m_tready;
  logic           s_ready_u, s_ready_s;
  logic [OW-1:0]  m_data_u, m_data_s;
  logic           m_valid_u, m_valid_s;
  logic           m_last_u, m_last_s;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  expect_t scoreboard[$];
  vector_t vec [7];

  always #5 clk = ~clk;

  axis_adder_tree #(.WIDTH(W), .NUM_OPERANDS(N), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_ready_u),
    .m_axis_tdata(m_data_u), .m_axis_tvalid(m_valid_u), .m_axis_tlast(m_last_u),
    .m_axis_tready(m_tready)
  );

  axis_adder_tree #(.WIDTH(W), .NUM_OPERANDS(N), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_ready_s),
    .m_axis_tdata(m_data_s), .m_axis_tvalid(m_valid_s), .m_axis_tlast(m_last_s),
    .m_axis_tready(m_tready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] data, input logic valid, input logic last, input logic ready);
    s_tdata  = data;
    s_tvalid = valid;
    s_tlast  = last;
    m_tready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic done in plain integers, independent of bit tricks
  function automatic expect_t model(input logic [N*W-1:0] data, input logic last);
    expect_t e;
    int su, ss, v;
    su = 0;
    ss = 0;
    for (int k = 0; k < N; k++) begin
      v  = int'(data[k*W +: W]);
      su = su + v;
      ss = ss + ((v >= 8) ? v - 16 : v);
    end
    e.sum_u = su[OW-1:0];
    e.sum_s = ss[OW-1:0];
    e.last  = last;
    return e;
  endfunction

  // Scoreboard and AXI stability monitor, sampled mid-cycle
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    expect_t e;
    if (reset === 1'b1) begin
      scoreboard.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid_held", 32'(m_valid_u), 1);
        checkOutput("stall_data_stable", 32'(m_data_u), 32'(prev_data));
        checkOutput("stall_last_stable", 32'(m_last_u), 32'(prev_last));
      end
      if (m_valid_u === 1'b1 && m_tready === 1'b1) begin
        out_count++;
        if (scoreboard.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got sum %0d, expected no output", m_data_u);
        end else begin
          e = scoreboard.pop_front();
          checkOutput("sb_sum_unsigned", 32'(m_data_u), 32'(e.sum_u));
          checkOutput("sb_sum_signed", 32'(m_data_s), 32'(e.sum_s));
          checkOutput("sb_tlast", 32'(m_last_u), 32'(e.last));
        end
      end
      if (s_tvalid === 1'b1 && s_ready_u === 1'b1) begin
        scoreboard.push_back(model(s_tdata, s_tlast));
      end
      prev_stall = (m_valid_u === 1'b1 && m_tready === 1'b0);
      prev_data  = m_data_u;
      prev_last  = m_last_u;
    end
  end

  initial begin
    int bubbles;
    int start_count;

    vec[0] = '{{4'd15, 4'd15, 4'd15}, 1'b1, 6'd45, 6'h3D};
    vec[1] = '{{4'd8,  4'd8,  4'd8 }, 1'b0, 6'd24, 6'h28};
    vec[2] = '{{4'd0,  4'd15, 4'd7 }, 1'b1, 6'd22, 6'd6 };
    vec[3] = '{{4'd0,  4'd0,  4'd0 }, 1'b0, 6'd0,  6'd0 };
    vec[4] = '{{4'd3,  4'd2,  4'd1 }, 1'b1, 6'd6,  6'd6 };
    vec[5] = '{{4'd7,  4'd7,  4'd7 }, 1'b0, 6'd21, 6'd21};
    vec[6] = '{{4'd12, 4'd4,  4'd9 }, 1'b1, 6'd25, 6'h39};

    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_s_ready", 32'(s_ready_u), 0);
    checkOutput("reset_s_ready_signed", 32'(s_ready_s), 0);
    checkOutput("reset_m_valid", 32'(m_valid_u), 0);
    checkOutput("reset_m_data", 32'(m_data_u), 0);
    checkOutput("reset_m_last", 32'(m_last_u), 0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(s_ready_u), 1);

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vec[i].tdata, 1'b1, vec[i].last, 1'b1);
      checkOutput("vec_s_ready", 32'(s_ready_u), 1);
      tick();
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      checkOutput("vec_not_early", 32'(m_valid_u), 0);
      tick();
      checkOutput("vec_valid_unsigned", 32'(m_valid_u), 1);
      checkOutput("vec_valid_signed", 32'(m_valid_s), 1);
      checkOutput("vec_sum_unsigned", 32'(m_data_u), 32'(vec[i].sum_u));
      checkOutput("vec_sum_signed", 32'(m_data_s), 32'(vec[i].sum_s));
      checkOutput("vec_tlast", 32'(m_last_s), 32'(vec[i].last));
    end
    tick();

    $display("[TB] backpressure A B C");
    applyStimulus(vec[4].tdata, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_accept_a", 32'(s_ready_u), 1);
    tick();
    applyStimulus(vec[0].tdata, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_accept_b", 32'(s_ready_u), 1);
    tick();
    applyStimulus(vec[1].tdata, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_full_stalls_c", 32'(s_ready_u), 0);
      checkOutput("bp_hold_valid", 32'(m_valid_u), 1);
      checkOutput("bp_hold_sum_a", 32'(m_data_u), 6);
      tick();
    end
    m_tready = 1'b1;
    #1;
    checkOutput("bp_ready_through", 32'(s_ready_u), 1);
    tick();
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_sum_b", 32'(m_data_u), 45);
    checkOutput("bp_last_b", 32'(m_last_u), 0);
    tick();
    checkOutput("bp_sum_c", 32'(m_data_s), 32'(6'h28));
    checkOutput("bp_last_c", 32'(m_last_u), 1);
    tick();
    checkOutput("bp_drained", 32'(m_valid_u), 0);

    $display("[TB] streaming 100 beats");
    bubbles     = 0;
    start_count = out_count;
    for (int i = 0; i < 100; i++) begin
      applyStimulus((N*W)'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      if (s_ready_u !== 1'b1) bubbles++;
      tick();
      if (i >= 1 && m_valid_u !== 1'b1) bubbles++;
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("stream_bubbles", 32'(bubbles), 0);
    checkOutput("stream_out_count", 32'(out_count - start_count), 100);

    $display("[TB] random stall");
    for (int i = 0; i < 300; i++) begin
      applyStimulus((N*W)'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    checkOutput("stall_sb_empty", 32'(scoreboard.size()), 0);

    $display("[TB] reset mid-stream");
    applyStimulus(vec[0].tdata, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(vec[1].tdata, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mid_full", 32'(s_ready_u), 0);
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("mid_reset_s_ready", 32'(s_ready_u), 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_after_valid", 32'(m_valid_u), 0);
    checkOutput("mid_after_s_ready", 32'(s_ready_u), 1);
    applyStimulus(vec[2].tdata, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("mid_first_valid", 32'(m_valid_u), 1);
    checkOutput("mid_first_unsigned", 32'(m_data_u), 22);
    checkOutput("mid_first_signed", 32'(m_data_s), 6);
    repeat (4) tick();
    checkOutput("mid_no_ghost", 32'(m_valid_u), 0);
    checkOutput("mid_sb_empty", 32'(scoreboard.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
